// File: rtl/fp16_dot_feeder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fp16_dot_feeder_if
// Description : Job, operand, MAC and result signals of the FP16 dot feeder.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp16_dot_feeder_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             in_ready;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic             mac_clr;
    logic [15:0]      mac_result;
    logic             out_valid;
    logic [15:0]      out_data;
    logic             out_ready;

    // Environment side: job source, operand source, MAC and result sink.
    modport master (
        output start, len, in_valid, in_a, in_b, mac_result, out_ready,
        input  busy, in_ready, mac_a, mac_b, mac_clr, out_valid, out_data
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, mac_result, out_ready,
        output busy, in_ready, mac_a, mac_b, mac_clr, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/fp16_dot_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fp16_dot_feeder
// Description : Buffers a job of FP16 operand pairs and sequences them to MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_dot_feeder #(
    parameter int LEN_W   = 8,
    parameter int DEPTH   = 4,
    parameter int MAC_LAT = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fp16_dot_feeder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [AW:0]   c_depth      = (AW+1)'(DEPTH);
    localparam logic [DW-1:0] c_drain_last = DW'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_acc_cnt;
    logic [LEN_W-1:0]  r_fed_cnt;
    logic [DW-1:0]     r_drain_cnt;

    logic [15:0]       r_mem_a [DEPTH];
    logic [15:0]       r_mem_b [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    logic [15:0]       r_mac_a;
    logic [15:0]       r_mac_b;
    logic              r_mac_clr;
    logic [15:0]       r_out_data;

    logic              w_full;
    logic              w_empty;
    logic              w_in_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_last_feed;
    logic              w_drain_done;
    logic              w_zero_job;

    assign w_full       = (r_count == c_depth);
    assign w_empty      = (r_count == '0);
    // Pairs beyond the job length stay upstream for the next job.
    assign w_in_ready   = ((r_state == S_CLEAR) || (r_state == S_FEED)) &&
                          !w_full && (r_acc_cnt < r_len);
    assign w_push       = bus.in_valid && w_in_ready;
    assign w_pop        = (r_state == S_FEED) && !w_empty;
    assign w_last_feed  = ((r_fed_cnt + 1'b1) == r_len);
    assign w_drain_done = (r_drain_cnt == c_drain_last);
    assign w_zero_job   = (r_state == S_IDLE) && bus.start && (bus.len == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.len == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: w_next = S_FEED;
            S_FEED: begin
                if (w_pop && w_last_feed) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len       <= '0;
            r_acc_cnt   <= '0;
            r_fed_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_acc_cnt <= '0;
                r_fed_cnt <= '0;
                if (bus.start) begin
                    r_len <= bus.len;
                end
            end else begin
                if (w_push) begin
                    r_acc_cnt <= r_acc_cnt + 1'b1;
                end
                if (w_pop) begin
                    r_fed_cnt <= r_fed_cnt + 1'b1;
                end
            end
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= bus.in_a;
            r_mem_b[r_wr_ptr] <= bus.in_b;
        end
    end

    // Non-pop cycles present +0 operands so the accumulator is unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mac_a    <= 16'h0000;
            r_mac_b    <= 16'h0000;
            r_mac_clr  <= 1'b0;
            r_out_data <= 16'h0000;
        end else begin
            r_mac_clr <= (w_next == S_CLEAR);
            r_mac_a   <= w_pop ? r_mem_a[r_rd_ptr] : 16'h0000;
            r_mac_b   <= w_pop ? r_mem_b[r_rd_ptr] : 16'h0000;
            if (w_zero_job) begin
                r_out_data <= 16'h0000;
            end else if ((r_state == S_DRAIN) && w_drain_done) begin
                r_out_data <= bus.mac_result;
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.in_ready  = w_in_ready;
    assign bus.mac_a     = r_mac_a;
    assign bus.mac_b     = r_mac_b;
    assign bus.mac_clr   = r_mac_clr;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_data  = r_out_data;
endmodule
`default_nettype wire

// File: tb/tb_fp16_dot_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fp16_dot_feeder
// Description : Directed scoreboard bench for fp16_dot_feeder with a MAC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_dot_feeder;
    localparam int LEN_W   = 8;
    localparam int DEPTH   = 4;
    localparam int MAC_LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fp16_dot_feeder_if #(.LEN_W(LEN_W)) bus();

    fp16_dot_feeder #(
        .LEN_W   (LEN_W),
        .DEPTH   (DEPTH),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb [$];
    logic [15:0] qa [$];
    logic [15:0] qb [$];
    bit          meas = 1'b0;
    int          n_acc = 0, n_rdy = 0, n_clr = 0, n_zero = 0, n_nz = 0;
    real         acc = 0.0;

    function automatic real fp2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        m = real'(int'(h[9:0])) / 1024.0;
        if (e == 0) e = 1;
        else        m = m + 1.0;
        e = e - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2fp(input real r);
        real  m;
        int   e;
        int   f;
        logic s;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = int'((m - 1.0) * 1024.0);
        if (f == 1024) begin f = 0; e++; end
        return {s, 5'(e + 15), 10'(f)};
    endfunction

    // Accumulator register plus combinational read-out gives the two-edge
    // operand-to-capture latency of MAC_LAT = 2.
    always @(posedge clk) begin
        acc <= bus.mac_clr ? 0.0 : acc + fp2r(bus.mac_a) * fp2r(bus.mac_b);
    end
    always_comb bus.mac_result = r2fp(acc);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected result", int'(bus.out_data), -1);
            end else begin
                chk("out_data", int'(bus.out_data), int'(sb.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (meas) begin
            if (bus.in_valid && bus.in_ready) n_acc++;
            if (bus.in_ready) n_rdy++;
            if (bus.mac_clr) n_clr++;
            else if (bus.busy && !bus.out_valid) begin
                if (bus.mac_a == 16'h0 && bus.mac_b == 16'h0) n_zero++;
                else n_nz++;
            end
        end
    end

    task automatic feeder(input int gap);
        int n = 0;
        int guard = 0;
        bit ok;
        while (qa.size() > 0 && !bus.out_valid && guard < 300) begin
            bus.in_valid = 1'b1;
            bus.in_a     = qa[0];
            bus.in_b     = qb[0];
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            guard++;
            if (ok) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
                n++;
                if (n == 1 && gap > 0) begin
                    bus.in_valid = 1'b0;
                    repeat (gap) begin @(posedge clk); #1; end
                end
            end
        end
        bus.in_valid = (qa.size() > 0);
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        qa.push_back(a);
        qb.push_back(b);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " busy"},      int'(bus.busy),      0);
        chk({nm, " in_ready"},  int'(bus.in_ready),  0);
        chk({nm, " mac_a"},     int'(bus.mac_a),     0);
        chk({nm, " mac_b"},     int'(bus.mac_b),     0);
        chk({nm, " mac_clr"},   int'(bus.mac_clr),   0);
        chk({nm, " out_valid"}, int'(bus.out_valid), 0);
        chk({nm, " out_data"},  int'(bus.out_data),  0);
    endtask

    task automatic run_job(input string nm, input int l, input int gap,
                           input logic [15:0] exp, input int exp_lat,
                           input int bp, input bit poke_start);
        int lat;
        int a0, r0, c0, z0, nz0;
        sb.push_back(exp);
        a0 = n_acc; r0 = n_rdy; c0 = n_clr; z0 = n_zero; nz0 = n_nz;
        bus.start = 1'b1;
        bus.len   = LEN_W'(l);
        meas      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        fork
            feeder(gap);
            begin
                while (!bus.out_valid && lat < 300) begin
                    @(posedge clk); #1;
                    lat++;
                end
            end
        join
        chk({nm, " latency"},  lat, exp_lat);
        chk({nm, " accepted"}, n_acc - a0, l);
        chk({nm, " fed pairs"}, n_nz - nz0, l);
        chk({nm, " zero bubbles"}, n_zero - z0, (l == 0) ? 0 : MAC_LAT + gap);
        chk({nm, " mac_clr pulses"}, n_clr - c0, (l == 0) ? 0 : 1);
        if (l == 0) chk({nm, " in_ready cycles"}, n_rdy - r0, 0);
        for (int i = 0; i < bp; i++) begin
            if (poke_start && i == 2) begin
                bus.start = 1'b1;
                bus.len   = LEN_W'(5);
            end
            @(negedge clk);
            chk({nm, " hold out_valid"}, int'(bus.out_valid), 1);
            chk({nm, " hold out_data"},  int'(bus.out_data), int'(exp));
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        meas = 1'b0;
        chk({nm, " idle after handshake"}, int'(bus.busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
        bus.in_a = 16'h0; bus.in_b = 16'h0; bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1;

        push_pair(16'h4200, 16'h4400);
        push_pair(16'h3E00, 16'h4040);
        push_pair(16'h3800, 16'h4000);
        run_job("basic", 3, 0, 16'h4C0C, 1 + 3 + MAC_LAT, 0, 1'b0);

        push_pair(16'h4200, 16'h4400);
        push_pair(16'h3E00, 16'h4040);
        push_pair(16'h3800, 16'h4000);
        run_job("gap", 3, 2, 16'h4C0C, 1 + 3 + MAC_LAT + 2, 0, 1'b0);

        // 12.0 + 3.1875 = 15.1875; the third pair must wait for job 2.
        push_pair(16'h4200, 16'h4400);
        push_pair(16'h3E00, 16'h4040);
        push_pair(16'h3800, 16'h4000);
        run_job("over1", 2, 0, 16'h4B98, 1 + 2 + MAC_LAT, 0, 1'b0);
        chk("over1 pairs left upstream", qa.size(), 1);
        chk("over1 in_ready idle", int'(bus.in_ready), 0);
        run_job("over2", 1, 0, 16'h3C00, 1 + 1 + MAC_LAT, 0, 1'b0);

        run_job("len0", 0, 0, 16'h0000, 0, 0, 1'b0);

        push_pair(16'h4200, 16'h4400);
        run_job("backpressure", 1, 0, 16'h4A00, 1 + 1 + MAC_LAT, 5, 1'b1);

        bus.start = 1'b1;
        bus.len   = LEN_W'(3);
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h4200;
        bus.in_b     = 16'h4400;
        repeat (3) begin @(posedge clk); #1; end
        chk("midjob busy before reset", int'(bus.busy), 1);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset("midjob reset");
        @(posedge clk); #1;

        push_pair(16'h4000, 16'h4000);
        run_job("fresh", 1, 0, 16'h4400, 1 + 1 + MAC_LAT, 0, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
